// File: rtl/lb_pkg.sv
// Shared constants, types and ring-index helper for the 5-tap line buffer.
package lb_pkg;
  localparam int LB_LINES       = 4;
  localparam int LB_TAPS        = 5;
  localparam int LB_COLORDEPTH  = 8;
  localparam int LB_SCREENWIDTH = 1600;
  localparam int LB_ADDR_W      = $clog2(LB_SCREENWIDTH);
  localparam int LB_LATENCY     = 2;

  typedef logic [1:0] lb_sel_t;
  typedef logic [2:0] lb_cnt_t;

  // RAM holding the line k rows above the one currently being written.
  function automatic lb_sel_t lb_ring_idx(input lb_sel_t sel, input lb_sel_t k);
    return lb_sel_t'(sel - k);
  endfunction
endpackage

// File: rtl/lb_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// Stored data is never reset; a same-address read returns the old word.
module lb_sdp_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 1600,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/line_buffer_5tap.sv
// Four-line ring buffer giving five vertically aligned taps with 2-cycle latency.
// Define LB_EDGE_REPLICATE_EN to replicate the oldest stored row into masked taps.
module line_buffer_5tap
  import lb_pkg::*;
#(
  parameter int COLORDEPTH  = LB_COLORDEPTH,
  parameter int SCREENWIDTH = LB_SCREENWIDTH,
  parameter int ADDR_W      = LB_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] pix_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [COLORDEPTH-1:0] vect_out_0,
  output logic [COLORDEPTH-1:0] vect_out_1,
  output logic [COLORDEPTH-1:0] vect_out_2,
  output logic [COLORDEPTH-1:0] vect_out_3,
  output logic [COLORDEPTH-1:0] vect_out_4,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  line_end_o,
  output logic [2:0]            lines_o
);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(SCREENWIDTH - 1);
  localparam lb_cnt_t           CNT_MAX = lb_cnt_t'(LB_LINES);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              full_q, full_d;
  lb_sel_t           wsel_q, wsel_d;
  lb_cnt_t           cnt_q, cnt_d;
  logic              dv_prev_q, vs_prev_q;
  logic              line_end, frame_start, ram_we;

  logic [LB_LATENCY-1:0] dv_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [COLORDEPTH-1:0] pix1_q;
  lb_sel_t               sel1_q;
  lb_cnt_t               cnt1_q;
  logic [COLORDEPTH-1:0] rdata [LB_LINES];
  logic [COLORDEPTH-1:0] pad;
  logic [COLORDEPTH-1:0] tap_d [LB_TAPS];
  logic [COLORDEPTH-1:0] tap_q [LB_TAPS];
  lb_cnt_t               lines_q;
  logic                  dv_o_prev_q, line_end_q;

  assign line_end    = dv_prev_q & ~dv_i;
  assign frame_start = vs_i & ~vs_prev_q;
  // Once the pointer reaches the last column, the rest of an overlong line is dropped.
  assign ram_we      = dv_i & ~full_q;

  // Write pointer, ring select and stored-line count next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    full_d   = full_q;
    wsel_d   = wsel_q;
    cnt_d    = cnt_q;
    if (vs_i || line_end) begin
      wr_ptr_d = '0;
      full_d   = 1'b0;
    end else if (ram_we) begin
      if (wr_ptr_q == PTR_MAX) begin
        full_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // A frame start outranks a coincident line end.
    if (frame_start) begin
      wsel_d = 2'd0;
      cnt_d  = 3'd0;
    end else if (line_end) begin
      wsel_d = wsel_q + 2'd1;
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 3'd1;
    end else begin
      wsel_d = wsel_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      full_q    <= 1'b0;
      wsel_q    <= 2'd0;
      cnt_q     <= 3'd0;
      dv_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
      wsel_q    <= wsel_d;
      cnt_q     <= cnt_d;
      dv_prev_q <= dv_i;
      vs_prev_q <= vs_i;
    end
  end

  for (genvar g = 0; g < LB_LINES; g++) begin : g_ram
    lb_sdp_ram #(
      .DW   (COLORDEPTH),
      .DEPTH(SCREENWIDTH),
      .AW   (ADDR_W)
    ) u_ram (
      .clk    (clk),
      .we_i   (ram_we && (wsel_q == lb_sel_t'(g))),
      .waddr_i(wr_ptr_q),
      .wdata_i(pix_i),
      .raddr_i(wr_ptr_q),
      .rdata_o(rdata[g])
    );
  end

  // Stage 1: sideband pipe plus context captured alongside the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_pipe_q <= '0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
      pix1_q    <= '0;
      sel1_q    <= 2'd0;
      cnt1_q    <= 3'd0;
    end else begin
      dv_pipe_q <= {dv_pipe_q[LB_LATENCY-2:0], dv_i};
      hs_pipe_q <= {hs_pipe_q[LB_LATENCY-2:0], hs_i};
      vs_pipe_q <= {vs_pipe_q[LB_LATENCY-2:0], vs_i};
      pix1_q    <= pix_i;
      sel1_q    <= wsel_q;
      cnt1_q    <= cnt_q;
    end
  end

  // Tap selection and masking of rows not yet stored in this frame.
  always_comb begin
    pad = '0;
    for (int t = 0; t < LB_TAPS; t++) begin
      tap_d[t] = '0;
    end
    if (dv_pipe_q[0]) begin
      tap_d[LB_TAPS-1] = pix1_q;
`ifdef LB_EDGE_REPLICATE_EN
      if (cnt1_q == 3'd0) begin
        pad = pix1_q;
      end else begin
        pad = rdata[lb_ring_idx(sel1_q, lb_sel_t'(cnt1_q))];
      end
`endif
      for (int k = 1; k < LB_TAPS; k++) begin
        if (lb_cnt_t'(k) <= cnt1_q) begin
          tap_d[LB_TAPS-1-k] = rdata[lb_ring_idx(sel1_q, lb_sel_t'(k))];
        end else begin
          tap_d[LB_TAPS-1-k] = pad;
        end
      end
    end else begin
      pad = '0;
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < LB_TAPS; t++) begin
        tap_q[t] <= '0;
      end
      lines_q     <= 3'd0;
      dv_o_prev_q <= 1'b0;
      line_end_q  <= 1'b0;
    end else begin
      for (int t = 0; t < LB_TAPS; t++) begin
        tap_q[t] <= tap_d[t];
      end
      lines_q     <= cnt1_q;
      dv_o_prev_q <= dv_pipe_q[LB_LATENCY-1];
      line_end_q  <= dv_o_prev_q & ~dv_pipe_q[LB_LATENCY-1];
    end
  end

  assign vect_out_0 = tap_q[0];
  assign vect_out_1 = tap_q[1];
  assign vect_out_2 = tap_q[2];
  assign vect_out_3 = tap_q[3];
  assign vect_out_4 = tap_q[4];
  assign dv_o       = dv_pipe_q[LB_LATENCY-1];
  assign hs_o       = hs_pipe_q[LB_LATENCY-1];
  assign vs_o       = vs_pipe_q[LB_LATENCY-1];
  assign line_end_o = line_end_q;
  assign lines_o    = lines_q;
endmodule
